// File: rtl/pcm_fifo.sv
// pcm_fifo: first-word-fall-through sample buffer between the FIR output and
// the SPI slave. Pops on a synchronized rising edge of the MCU acknowledge.
module pcm_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [WIDTH-1:0]         din,
  input  logic                     din_valid,
  input  logic                     sdone,
  output logic [WIDTH-1:0]         dout,
  output logic                     data_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     underflow,
  output logic [7:0]               drop_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             rdy_q, rdy_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [7:0]       drop_q, drop_d;

  // sdone synchronizer, edge-detect delay flop, and a warm-up chain that marks
  // when s3 holds a genuine post-reset sample (blocks a pop from an sdone that
  // was already high while reset was asserted).
  logic             s1_q, s2_q, s3_q;
  logic [2:0]       live_q;

  logic pop, full, empty, pop_ok, wr_ok, drop;

  assign pop    = s2_q & ~s3_q & live_q[2];
  assign full   = (level_q == LW'(DEPTH));
  assign empty  = (level_q == '0);
  assign pop_ok = pop & ~empty;
  assign wr_ok  = din_valid & (~full | pop);
  assign drop   = din_valid & full & ~pop;

  // Next-state for pointers, level, head word and status.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    dout_d   = dout_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    drop_d   = drop_q;

    if (wr_ok)  wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok) rd_ptr_d = rd_ptr_q + AW'(1);

    case ({wr_ok, pop_ok})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    if (pop_ok) begin
      if (level_q == LW'(1)) dout_d = wr_ok ? din : '0;
      else                   dout_d = mem[rd_ptr_q + AW'(1)];
    end else if (wr_ok && empty) begin
      dout_d = din;
    end

    if (drop) begin
      ovf_d = 1'b1;
      if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end
    if (pop && empty) unf_d = 1'b1;

    rdy_d = (level_d != '0);
  end

  // Sample storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q] <= din;
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      dout_q   <= '0;
      rdy_q    <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      drop_q   <= '0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      live_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      dout_q   <= dout_d;
      rdy_q    <= rdy_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      drop_q   <= drop_d;
      s1_q     <= sdone;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      live_q   <= {live_q[1:0], 1'b1};
    end
  end

  assign dout       = dout_q;
  assign data_ready = rdy_q;
  assign level      = level_q;
  assign overflow   = ovf_q;
  assign underflow  = unf_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_pcm_fifo.sv
// tb_pcm_fifo: scoreboard bench for pcm_fifo against a queue-based model.
module tb_pcm_fifo;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] din = '0;
  logic        din_valid = 1'b0;
  logic        sdone = 1'b0;
  logic [15:0] dout;
  logic        data_ready;
  logic [4:0]  level;
  logic        overflow;
  logic        underflow;
  logic [7:0]  drop_count;

  pcm_fifo #(.DEPTH(DEPTH), .WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .din(din), .din_valid(din_valid),
    .sdone(sdone), .dout(dout), .data_ready(data_ready), .level(level),
    .overflow(overflow), .underflow(underflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] dout;
    int          level;
    bit          rdy;
    bit          ov;
    bit          un;
    int          dc;
  } exp_t;

  exp_t        expq[$];
  int unsigned total = 0;
  int unsigned bad = 0;

  // Reference model: FIFO contents, sticky flags, and sdone samples per edge
  // (2 = no valid sample since reset).
  logic [15:0] mq[$];
  bit          m_ov = 0, m_un = 0;
  int          m_dc = 0;
  int          h1 = 2, h2 = 2, h3 = 2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.dout  = (mq.size() > 0) ? mq[0] : 16'h0;
    e.level = mq.size();
    e.rdy   = (mq.size() > 0);
    e.ov    = m_ov;
    e.un    = m_un;
    e.dc    = m_dc;
    expq.push_back(e);
  endtask

  task automatic model_reset();
    mq.delete();
    m_ov = 0; m_un = 0; m_dc = 0;
    h1 = 2; h2 = 2; h3 = 2;
  endtask

  // One clock: drive inputs at the falling edge and predict the next rising edge.
  task automatic cyc(input bit v, input logic [15:0] d, input bit sd);
    bit pop;
    @(negedge clk);
    reset_n = 1'b1; din = d; din_valid = v; sdone = sd;
    pop = (h2 == 1) && (h3 == 0);
    if (pop) begin
      if (mq.size() > 0) void'(mq.pop_front());
      else m_un = 1;
    end
    if (v) begin
      if (mq.size() < DEPTH) mq.push_back(d);
      else begin
        m_ov = 1;
        if (m_dc < 255) m_dc++;
      end
    end
    h3 = h2; h2 = h1; h1 = sd ? 1 : 0;
    push_exp();
  endtask

  // Assert reset for n edges, checking outputs clear before any edge.
  task automatic rst(input bit sd, input int n);
    @(negedge clk);
    reset_n = 1'b0; din_valid = 1'b0; sdone = sd;
    #1;
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_level", 32'(level), 32'h0);
    chk("rst_ready", 32'(data_ready), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    chk("rst_unf", 32'(underflow), 32'h0);
    chk("rst_drop", 32'(drop_count), 32'h0);
    model_reset();
    push_exp();
    for (int i = 1; i < n; i++) begin
      @(negedge clk);
      push_exp();
    end
  endtask

  task automatic pulse();
    repeat (3) cyc(0, 16'h0, 1);
    repeat (3) cyc(0, 16'h0, 0);
  endtask

  // Monitor: compare DUT outputs just after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("dout", 32'(dout), 32'(e.dout));
        chk("level", 32'(level), 32'(e.level));
        chk("data_ready", 32'(data_ready), 32'(e.rdy));
        chk("overflow", 32'(overflow), 32'(e.ov));
        chk("underflow", 32'(underflow), 32'(e.un));
        chk("drop_count", 32'(drop_count), 32'(e.dc));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int hold;
    bit sd;
    rst(0, 3);

    // Single write, single pop.
    cyc(1, 16'h1234, 0);
    cyc(0, 16'h0, 0);
    pulse();

    // Fill, overflow by three, drain in order.
    for (int i = 1; i <= 16; i++) cyc(1, 16'(i), 0);
    cyc(1, 16'hAAAA, 0);
    cyc(1, 16'hBBBB, 0);
    cyc(1, 16'hCCCC, 0);
    repeat (16) pulse();

    // Long sdone high gives one pop; pop on empty flags underflow.
    for (int i = 0; i < 4; i++) cyc(1, 16'(16'h0100 + i), 0);
    repeat (50) cyc(0, 16'h0, 1);
    repeat (3) cyc(0, 16'h0, 0);
    repeat (3) pulse();
    pulse();

    // Write aligned with the pop edge: full, then level 1.
    rst(0, 2);
    for (int i = 0; i < 16; i++) cyc(1, 16'(16'h2000 + i), 0);
    cyc(0, 16'h0, 1);
    cyc(0, 16'h0, 1);
    cyc(1, 16'h5555, 1);
    repeat (3) cyc(0, 16'h0, 0);
    repeat (16) pulse();
    cyc(1, 16'h7777, 0);
    cyc(0, 16'h0, 1);
    cyc(0, 16'h0, 1);
    cyc(1, 16'h8888, 1);
    repeat (3) cyc(0, 16'h0, 0);
    pulse();

    // Drop counter saturation.
    for (int i = 0; i < 16; i++) cyc(1, 16'(i), 0);
    repeat (300) cyc(1, 16'($urandom), 0);

    // Reset mid-stream with sdone high; no pop until sdone falls and rises.
    rst(0, 2);
    for (int i = 0; i < 10; i++) cyc(1, 16'(16'h3000 + i), 0);
    repeat (4) cyc(0, 16'h0, 1);
    rst(1, 3);
    for (int i = 0; i < 3; i++) cyc(1, 16'(16'h4000 + i), 1);
    repeat (5) cyc(0, 16'h0, 1);
    repeat (3) cyc(0, 16'h0, 0);
    pulse();

    // Pointer wrap: 40 interleaved write/pop pairs.
    for (int i = 0; i < 40; i++) begin
      cyc(1, 16'(16'h5000 + i), 1);
      cyc(0, 16'h0, 1);
      cyc(0, 16'h0, 0);
      cyc(0, 16'h0, 0);
    end

    // Random traffic with legal sdone high/low times.
    rst(0, 2);
    sd = 0;
    hold = 3;
    for (int i = 0; i < 1500; i++) begin
      if (hold == 0) begin
        sd = ~sd;
        hold = $urandom_range(2, 6);
      end
      hold--;
      cyc(($urandom_range(0, 3) == 0), 16'($urandom), sd);
    end
    repeat (4) cyc(0, 16'h0, 0);

    @(posedge clk);
    #2;
    chk("scoreboard_drain", 32'(expq.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
